// File: rtl/m_float2fix_pipe_if.sv
// Stream bundle for the float-to-fixed converter: float beats in, fixed-point beats out.
// The converter takes the slave view; the producer/consumer pair takes the master view.
interface m_float2fix_pipe_if #(
    parameter int LANES = 8,
    parameter int OUT_W = 32
);
    logic                     src_valid;
    logic                     src_ready;
    logic [LANES*32-1:0]      src_data;
    logic                     round_mode;
    logic                     dst_valid;
    logic                     dst_ready;
    logic [LANES*OUT_W-1:0]   dst_data;
    logic [LANES-1:0]         dst_sat;

    modport master (
        output src_valid, src_data, round_mode, dst_ready,
        input  src_ready, dst_valid, dst_data, dst_sat
    );

    modport slave (
        input  src_valid, src_data, round_mode, dst_ready,
        output src_ready, dst_valid, dst_data, dst_sat
    );
endinterface

// File: rtl/m_float2fix_pipe.sv
// Two-stage, LANES-wide float32 to signed Q(OUT_W-FRAC_W).FRAC_W converter with
// per-beat rounding mode, per-lane saturation flags and a sticky saturation counter.
module m_float2fix_pipe #(
    parameter int LANES  = 8,
    parameter int OUT_W  = 32,
    parameter int FRAC_W = 16
) (
    input  logic                clk,
    input  logic                rstn,
    m_float2fix_pipe_if.slave   bus,
    output logic [15:0]         sat_cnt
);
    localparam logic [OUT_W-1:0] MAX_V  = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] MIN_V  = {1'b1, {(OUT_W-1){1'b0}}};
    localparam logic [OUT_W:0]   HALF_V = {2'b01, {(OUT_W-1){1'b0}}};

    // ovf marks a magnitude already too large for either sign before rounding
    typedef struct packed {
        logic             sign;
        logic             nan;
        logic             ovf;
        logic             guard;
        logic [OUT_W-1:0] mag;
    } lane_t;

    function automatic lane_t unpack_align(input logic [31:0] f);
        lane_t              l;
        logic [7:0]         e;
        logic [23:0]        mm;
        logic signed [10:0] sh;
        logic [10:0]        rs;
        logic [24:0]        ext;
        logic [63:0]        wide;
        logic               big;
        e    = f[30:23];
        mm   = {1'b1, f[22:0]};
        sh   = $signed({3'b000, e}) + $signed(11'(FRAC_W)) - 11'sd150;
        rs   = 11'(-sh);
        ext  = 25'd0;
        wide = 64'd0;
        big  = 1'b0;
        if (sh[10]) begin
            if (rs <= 11'd25) begin
                ext = {mm, 1'b0} >> rs[4:0];
            end else begin
                ext = 25'd0;
            end
            wide = 64'(ext[24:1]);
        end else begin
            if (sh > 11'sd39) begin
                big = 1'b1;
            end else begin
                wide = 64'(mm) << sh[5:0];
            end
        end
        l.sign  = f[31];
        l.nan   = 1'b0;
        l.guard = sh[10] & ext[0];
        l.ovf   = big | (|wide[63:OUT_W]);
        l.mag   = wide[OUT_W-1:0];
        if (e == 8'd0) begin
            l.ovf   = 1'b0;
            l.guard = 1'b0;
            l.mag   = {OUT_W{1'b0}};
        end else if (e == 8'hFF) begin
            l.guard = 1'b0;
            l.mag   = {OUT_W{1'b0}};
            l.nan   = |f[22:0];
            l.ovf   = ~(|f[22:0]);
        end else begin
            l.nan   = 1'b0;
        end
        return l;
    endfunction

    // Returns {sat, result}; the rounding carry is kept in the extra bit so it can saturate
    function automatic logic [OUT_W:0] round_sat(input lane_t l, input logic mode);
        logic [OUT_W:0]   rnd;
        logic [OUT_W-1:0] d;
        logic             s;
        rnd = {1'b0, l.mag} + (OUT_W+1)'(mode & l.guard);
        if (l.nan) begin
            d = {OUT_W{1'b0}};
            s = 1'b1;
        end else if (!l.sign) begin
            if (l.ovf || (rnd > {1'b0, MAX_V})) begin
                d = MAX_V;
                s = 1'b1;
            end else begin
                d = rnd[OUT_W-1:0];
                s = 1'b0;
            end
        end else begin
            if (l.ovf || (rnd > HALF_V)) begin
                d = MIN_V;
                s = 1'b1;
            end else begin
                d = OUT_W'(~rnd[OUT_W-1:0] + {{(OUT_W-1){1'b0}}, 1'b1});
                s = 1'b0;
            end
        end
        return {s, d};
    endfunction

    lane_t                   s1_lane_r [LANES];
    lane_t                   s1_next_s [LANES];
    logic                    s1_valid_r;
    logic                    s1_mode_r;
    logic                    s2_valid_r;
    logic [LANES*OUT_W-1:0]  dst_data_r;
    logic [LANES-1:0]        dst_sat_r;
    logic [LANES*OUT_W-1:0]  s2_data_s;
    logic [LANES-1:0]        s2_sat_s;
    logic [15:0]             sat_cnt_r;
    logic                    s1_en_s;
    logic                    s2_en_s;

    assign s2_en_s       = !s2_valid_r || bus.dst_ready;
    assign s1_en_s       = !s1_valid_r || s2_en_s;
    assign bus.src_ready = s1_en_s;
    assign bus.dst_valid = s2_valid_r;
    assign bus.dst_data  = dst_data_r;
    assign bus.dst_sat   = dst_sat_r;
    assign sat_cnt       = sat_cnt_r;

    // S1 combinational unpack and alignment of every incoming lane
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            s1_next_s[i] = unpack_align(bus.src_data[32*i +: 32]);
        end
    end

    // S2 combinational rounding, sign application and saturation
    always_comb begin
        s2_data_s = {(LANES*OUT_W){1'b0}};
        s2_sat_s  = {LANES{1'b0}};
        for (int i = 0; i < LANES; i++) begin
            {s2_sat_s[i], s2_data_s[OUT_W*i +: OUT_W]} = round_sat(s1_lane_r[i], s1_mode_r);
        end
    end

    // S1 register: aligned lanes plus the beat's rounding mode
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_r <= 1'b0;
            s1_mode_r  <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                s1_lane_r[i] <= '0;
            end
        end else if (s1_en_s) begin
            s1_valid_r <= bus.src_valid;
            s1_mode_r  <= bus.round_mode;
            for (int i = 0; i < LANES; i++) begin
                s1_lane_r[i] <= s1_next_s[i];
            end
        end
    end

    // S2 register: output beat, held while the consumer stalls
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_valid_r <= 1'b0;
            dst_data_r <= {(LANES*OUT_W){1'b0}};
            dst_sat_r  <= {LANES{1'b0}};
        end else if (s2_en_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                dst_data_r <= s2_data_s;
                dst_sat_r  <= s2_sat_s;
            end
        end
    end

    // Saturation event counter: one per accepted output beat, sticks at all-ones
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sat_cnt_r <= 16'd0;
        end else if (s2_valid_r && bus.dst_ready && (|dst_sat_r) && (sat_cnt_r != 16'hFFFF)) begin
            sat_cnt_r <= sat_cnt_r + 16'd1;
        end
    end
endmodule
